vga_gain_decode: RTL and testbench

- Reverse direction of the VGA control path: takes the 6-bit thermometer gain-control word and recovers the 3-bit binary level (0..6).
- Checks code legality (bubbles) and requires the word to be stable for STABLE_CYCLES valid samples before delivering it.
- Delivers the level over a valid/ready handshake to the digital gain-tracking / readback logic.

---
 rtl/vga_gain_decode_pkg.sv | 9 +
 rtl/vga_gain_decode_if.sv | 23 ++
 rtl/vga_gain_decode_therm_to_bin.sv | 20 ++
 rtl/vga_gain_decode.sv | 107 ++++++++++
 tb/tb_vga_gain_decode.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_gain_decode_pkg.sv
// vga_gain_pkg: shared FSM state type, default widths and counter-width helper
package vga_gain_pkg;
   typedef enum logic [1:0] {IDLE, SETTLE, PRESENT, HOLD} state_e;
   localparam int THERM_W_DEF  = 6;
   localparam int OUTPUT_W_DEF = 3;
   function automatic int stab_cnt_width(input int stable_cycles);
      return $clog2(stable_cycles + 1);
   endfunction
endpackage

// File: rtl/vga_gain_decode_if.sv
// vga_gain_decode_if: thermometer sample input, level handshake and bubble status
interface vga_gain_decode_if #(
   parameter int THERM_WIDTH   = 6,
   parameter int OUTPUT_WIDTH  = 3,
   parameter int ERR_CNT_WIDTH = 8
);
   logic [THERM_WIDTH-1:0]   vga_control_in;
   logic                     in_valid;
   logic [OUTPUT_WIDTH-1:0]  level_out;
   logic                     level_valid;
   logic                     level_ready;
   logic                     bubble_err;
   logic                     err_clear;
   logic [ERR_CNT_WIDTH-1:0] bubble_cnt;
   modport master (
      output vga_control_in, in_valid, level_ready, err_clear,
      input  level_out, level_valid, bubble_err, bubble_cnt
   );
   modport slave (
      input  vga_control_in, in_valid, level_ready, err_clear,
      output level_out, level_valid, bubble_err, bubble_cnt
   );
endinterface

// File: rtl/vga_gain_decode_therm_to_bin.sv
// therm_to_bin: combinational thermometer legality check and popcount level
module therm_to_bin
   import vga_gain_pkg::*;
#(
   parameter int THERM_WIDTH  = THERM_W_DEF,
   parameter int OUTPUT_WIDTH = OUTPUT_W_DEF
) (
   input  logic [THERM_WIDTH-1:0]  code,
   output logic                    legal,
   output logic [OUTPUT_WIDTH-1:0] level
);
   logic [THERM_WIDTH-1:0] code_inc;
   // a legal LSB-filled code plus one carries through every set bit, leaving no overlap
   assign code_inc = code + THERM_WIDTH'(1);
   assign legal    = (code & code_inc) == '0;
   always_comb begin
      level = '0;
      for (int i = 0; i < THERM_WIDTH; i++) level = level + OUTPUT_WIDTH'(code[i]);
   end
endmodule

// File: rtl/vga_gain_decode.sv
// vga_gain_decode: recovers a stable binary gain level from the thermometer word
// and delivers each new level once over a valid/ready handshake.
module vga_gain_decode
   import vga_gain_pkg::*;
#(
   parameter int THERM_WIDTH   = THERM_W_DEF,
   parameter int OUTPUT_WIDTH  = OUTPUT_W_DEF,
   parameter int STABLE_CYCLES = 4,
   parameter int ERR_CNT_WIDTH = 8
) (
   input logic               clk,
   input logic               rst,
   input logic               gnd,
   vga_gain_decode_if.slave  bus
);
   localparam int CW = stab_cnt_width(STABLE_CYCLES);
   state_e                   state_q, state_d;
   logic [OUTPUT_WIDTH-1:0]  cand_q, cand_d, last_q, last_d, level_out_q, level_out_d, lvl;
   logic [CW-1:0]            cnt_q, cnt_d, cnt_inc;
   logic                     level_valid_q, level_valid_d, bubble_err_q, bubble_err_d;
   logic [ERR_CNT_WIDTH-1:0] bubble_cnt_q, bubble_cnt_d;
   logic                     legal, sample, bubble, unused_gnd;
   assign unused_gnd = gnd;
   therm_to_bin #(.THERM_WIDTH(THERM_WIDTH), .OUTPUT_WIDTH(OUTPUT_WIDTH)) u_dec (
      .code (bus.vga_control_in),
      .legal(legal),
      .level(lvl)
   );
   assign sample  = bus.in_valid & legal;
   assign bubble  = bus.in_valid & ~legal;
   assign cnt_inc = cnt_q + CW'(1);
   always_comb begin
      state_d       = state_q;
      cand_d        = cand_q;
      cnt_d         = cnt_q;
      last_d        = last_q;
      level_out_d   = level_out_q;
      level_valid_d = level_valid_q;
      bubble_err_d  = bubble ? 1'b1 : bus.err_clear ? 1'b0 : bubble_err_q;
      bubble_cnt_d  = (bubble && bubble_cnt_q != '1) ? bubble_cnt_q + ERR_CNT_WIDTH'(1) : bubble_cnt_q;
      case (state_q)
         IDLE, HOLD: begin
            // HOLD suppresses re-delivery of the level already handed downstream
            if (sample && (state_q == IDLE || lvl != last_q)) begin
               cand_d = lvl;
               cnt_d  = CW'(1);
               if (STABLE_CYCLES == 1) begin
                  state_d       = PRESENT;
                  level_out_d   = lvl;
                  level_valid_d = 1'b1;
               end else begin
                  state_d = SETTLE;
               end
            end
         end
         SETTLE: begin
            if (bubble) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (sample && lvl != cand_q) begin
               cand_d = lvl;
               cnt_d  = CW'(1);
            end else if (sample) begin
               cnt_d = cnt_inc;
               if (cnt_inc == CW'(STABLE_CYCLES)) begin
                  state_d       = PRESENT;
                  level_out_d   = cand_q;
                  level_valid_d = 1'b1;
               end
            end
         end
         PRESENT: begin
            if (level_valid_q && bus.level_ready) begin
               last_d        = cand_q;
               level_valid_d = 1'b0;
               state_d       = HOLD;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         cand_q        <= '0;
         cnt_q         <= '0;
         last_q        <= '0;
         level_out_q   <= '0;
         level_valid_q <= 1'b0;
         bubble_err_q  <= 1'b0;
         bubble_cnt_q  <= '0;
      end else begin
         state_q       <= state_d;
         cand_q        <= cand_d;
         cnt_q         <= cnt_d;
         last_q        <= last_d;
         level_out_q   <= level_out_d;
         level_valid_q <= level_valid_d;
         bubble_err_q  <= bubble_err_d;
         bubble_cnt_q  <= bubble_cnt_d;
      end
   end
   assign bus.level_out   = level_out_q;
   assign bus.level_valid = level_valid_q;
   assign bus.bubble_err  = bubble_err_q;
   assign bus.bubble_cnt  = bubble_cnt_q;
endmodule

// File: tb/tb_vga_gain_decode.sv
// tb_vga_gain_decode: scenario tasks with a delivery scoreboard for vga_gain_decode
module tb_vga_gain_decode;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic gnd = 1'b0;
   always #5 clk = ~clk;
   vga_gain_decode_if #(.THERM_WIDTH(6), .OUTPUT_WIDTH(3), .ERR_CNT_WIDTH(8)) vif ();
   vga_gain_decode #(.THERM_WIDTH(6), .OUTPUT_WIDTH(3), .STABLE_CYCLES(4), .ERR_CNT_WIDTH(8)) dut (
      .clk(clk),
      .rst(rst),
      .gnd(gnd),
      .bus(vif)
   );
   int checks = 0;
   int errors = 0;
   logic [2:0] exp_q[$];
   logic [2:0] mon_exp;
   // each accepted handshake must match the oldest expected level
   always @(negedge clk) begin
      if (rst && vif.level_valid && vif.level_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_delivery: got level %0d, required no delivery", vif.level_out);
         end else begin
            mon_exp = exp_q.pop_front();
            if (vif.level_out !== mon_exp) begin
               errors++;
               $display("FAIL delivered_level: got %0d required %0d", vif.level_out, mon_exp);
            end
         end
      end
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   task automatic step(input logic [5:0] c, input logic v);
      vif.vga_control_in = c;
      vif.in_valid       = v;
      @(posedge clk);
      #1;
   endtask
   task automatic wait_drain(input string name);
      int n = 0;
      vif.in_valid = 1'b0;
      while (exp_q.size() != 0 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d deliveries pending, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask
   task automatic test_reset();
      checks++;
      if ({vif.level_valid, vif.level_out, vif.bubble_err, vif.bubble_cnt} !== 13'd0) begin
         errors++;
         $display("FAIL reset_state: got valid=%0d out=%0d err=%0d cnt=%0d required all 0",
                  vif.level_valid, vif.level_out, vif.bubble_err, vif.bubble_cnt);
      end
   endtask
   task automatic test_basic();
      vif.level_ready = 1'b1;
      exp_q.push_back(3'd3);
      repeat (3) step(6'b000111, 1'b1);
      checks++;
      if (vif.level_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_early: got valid=%0d required 0", vif.level_valid);
      end
      step(6'b000111, 1'b1);
      checks++;
      if ({vif.level_valid, vif.level_out} !== {1'b1, 3'd3}) begin
         errors++;
         $display("FAIL basic_latency: got valid=%0d out=%0d required valid=1 out=3", vif.level_valid, vif.level_out);
      end
      wait_drain("basic_drain");
      checks++;
      if (vif.level_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_accept: got valid=%0d required 0", vif.level_valid);
      end
      repeat (3) step(6'b000111, 1'b1);
   endtask
   task automatic test_settle_restart();
      exp_q.push_back(3'd4);
      repeat (2) step(6'b000011, 1'b1);
      repeat (3) step(6'b001111, 1'b1);
      checks++;
      if (vif.level_valid !== 1'b0) begin
         errors++;
         $display("FAIL restart_early: got valid=%0d required 0", vif.level_valid);
      end
      step(6'b001111, 1'b1);
      checks++;
      if ({vif.level_valid, vif.level_out} !== {1'b1, 3'd4}) begin
         errors++;
         $display("FAIL restart_level: got valid=%0d out=%0d required valid=1 out=4", vif.level_valid, vif.level_out);
      end
      wait_drain("restart_drain");
   endtask
   task automatic test_bubble();
      step(6'b000011, 1'b1);
      step(6'b000101, 1'b1);
      checks++;
      if ({vif.bubble_err, vif.bubble_cnt} !== {1'b1, 8'd1}) begin
         errors++;
         $display("FAIL bubble_set: got err=%0d cnt=%0d required err=1 cnt=1", vif.bubble_err, vif.bubble_cnt);
      end
      vif.err_clear = 1'b1;
      step(6'b000000, 1'b0);
      checks++;
      if ({vif.bubble_err, vif.bubble_cnt} !== {1'b0, 8'd1}) begin
         errors++;
         $display("FAIL bubble_clear: got err=%0d cnt=%0d required err=0 cnt=1", vif.bubble_err, vif.bubble_cnt);
      end
      step(6'b000101, 1'b1);
      vif.err_clear = 1'b0;
      checks++;
      if ({vif.bubble_err, vif.bubble_cnt} !== {1'b1, 8'd2}) begin
         errors++;
         $display("FAIL bubble_set_wins: got err=%0d cnt=%0d required err=1 cnt=2", vif.bubble_err, vif.bubble_cnt);
      end
      // the bubble must have restarted stability counting from IDLE
      exp_q.push_back(3'd2);
      repeat (3) step(6'b000011, 1'b1);
      checks++;
      if (vif.level_valid !== 1'b0) begin
         errors++;
         $display("FAIL bubble_to_idle: got valid=%0d required 0", vif.level_valid);
      end
      step(6'b000011, 1'b1);
      checks++;
      if ({vif.level_valid, vif.level_out} !== {1'b1, 3'd2}) begin
         errors++;
         $display("FAIL bubble_recover: got valid=%0d out=%0d required valid=1 out=2", vif.level_valid, vif.level_out);
      end
      wait_drain("bubble_drain");
   endtask
   task automatic test_backpressure();
      vif.level_ready = 1'b0;
      exp_q.push_back(3'd3);
      repeat (4) step(6'b000111, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step(6'b111111, 1'b1);
         checks++;
         if ({vif.level_valid, vif.level_out} !== {1'b1, 3'd3}) begin
            errors++;
            $display("FAIL backpressure_hold[%0d]: got valid=%0d out=%0d required valid=1 out=3",
                     i, vif.level_valid, vif.level_out);
         end
      end
      vif.level_ready = 1'b1;
      step(6'b111111, 1'b1);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL backpressure_accept: got %0d pending, required 0", exp_q.size());
         exp_q.delete();
      end
      exp_q.push_back(3'd6);
      repeat (3) step(6'b111111, 1'b1);
      checks++;
      if (vif.level_valid !== 1'b0) begin
         errors++;
         $display("FAIL backpressure_ignored_sample: got valid=%0d required 0", vif.level_valid);
      end
      step(6'b111111, 1'b1);
      checks++;
      if ({vif.level_valid, vif.level_out} !== {1'b1, 3'd6}) begin
         errors++;
         $display("FAIL backpressure_next: got valid=%0d out=%0d required valid=1 out=6", vif.level_valid, vif.level_out);
      end
      wait_drain("backpressure_drain");
   endtask
   task automatic test_sparse_valid();
      exp_q.push_back(3'd1);
      for (int i = 0; i < 8; i++) begin
         step(6'b000001, (i % 2) == 0);
         if (i == 5) begin
            checks++;
            if (vif.level_valid !== 1'b0) begin
               errors++;
               $display("FAIL sparse_early: got valid=%0d required 0", vif.level_valid);
            end
         end
         if (i == 6) begin
            checks++;
            if ({vif.level_valid, vif.level_out} !== {1'b1, 3'd1}) begin
               errors++;
               $display("FAIL sparse_level: got valid=%0d out=%0d required valid=1 out=1", vif.level_valid, vif.level_out);
            end
         end
      end
      wait_drain("sparse_drain");
      repeat (8) step(6'b000001, 1'b1);
      checks++;
      if ({vif.level_valid, vif.level_out} !== {1'b0, 3'd1}) begin
         errors++;
         $display("FAIL hold_no_redeliver: got valid=%0d out=%0d required valid=0 out=1", vif.level_valid, vif.level_out);
      end
   endtask
   task automatic test_async_reset();
      vif.level_ready = 1'b0;
      step(6'b000101, 1'b1);
      step(6'b000010, 1'b1);
      repeat (4) step(6'b000111, 1'b1);
      checks++;
      if ({vif.level_valid, vif.level_out} !== {1'b1, 3'd3}) begin
         errors++;
         $display("FAIL reset_pre: got valid=%0d out=%0d required valid=1 out=3", vif.level_valid, vif.level_out);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({vif.level_valid, vif.level_out, vif.bubble_err, vif.bubble_cnt} !== 13'd0) begin
         errors++;
         $display("FAIL async_reset: got valid=%0d out=%0d err=%0d cnt=%0d required all 0",
                  vif.level_valid, vif.level_out, vif.bubble_err, vif.bubble_cnt);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      vif.level_ready = 1'b1;
   endtask
   task automatic test_saturation();
      repeat (254) step(6'b101010, 1'b1);
      checks++;
      if (vif.bubble_cnt !== 8'd254) begin
         errors++;
         $display("FAIL sat_254: got cnt=%0d required 254", vif.bubble_cnt);
      end
      step(6'b010000, 1'b1);
      checks++;
      if (vif.bubble_cnt !== 8'd255) begin
         errors++;
         $display("FAIL sat_255: got cnt=%0d required 255", vif.bubble_cnt);
      end
      repeat (45) step(6'b111110, 1'b1);
      checks++;
      if ({vif.bubble_err, vif.bubble_cnt} !== {1'b1, 8'd255}) begin
         errors++;
         $display("FAIL sat_300: got err=%0d cnt=%0d required err=1 cnt=255", vif.bubble_err, vif.bubble_cnt);
      end
   endtask
   initial begin
      vif.vga_control_in = '0;
      vif.in_valid       = 1'b0;
      vif.level_ready    = 1'b0;
      vif.err_clear      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b1;
      test_basic();
      test_settle_restart();
      test_bubble();
      test_backpressure();
      test_sparse_valid();
      test_async_reset();
      test_saturation();
      wait_drain("final_drain");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
